// File: rtl/array_cnt_pkg.sv
// Shared types and default sizes for the counter array and its threshold monitor.
package array_cnt_pkg;

  localparam int W_DEF = 6;
  localparam int N_DEF = 8;

  typedef enum logic {
    RAISE = 1'b0,
    CLEAR = 1'b1
  } evt_type_e;

endpackage : array_cnt_pkg

// File: rtl/array_cnt_monitor_if.sv
// Valid/ready event channel from the threshold monitor to its consumer.
interface array_cnt_monitor_if #(
  parameter int W   = array_cnt_pkg::W_DEF,
  parameter int IDW = $clog2(array_cnt_pkg::N_DEF)
) ();
  import array_cnt_pkg::*;

  logic           evt_valid;
  logic           evt_ready;
  logic [IDW-1:0] evt_id;
  evt_type_e      evt_type;
  logic [W-1:0]   evt_cnt;

  modport master (
    output evt_valid, evt_id, evt_type, evt_cnt,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_id, evt_type, evt_cnt,
    output evt_ready
  );

endinterface : array_cnt_monitor_if

// File: rtl/array_cnt_monitor_out_reg.sv
// Single-entry valid/ready output register; tells the scanner when a new event may load.
module cnt_mon_out_reg
  import array_cnt_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int IDW = $clog2(N_DEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [IDW-1:0]      id_i,
  input  evt_type_e           type_i,
  input  logic [W-1:0]        cnt_i,
  output logic                slot_free_o,
  array_cnt_monitor_if.master evt
);

  logic           valid_q, valid_d;
  logic [IDW-1:0] id_q, id_d;
  evt_type_e      type_q, type_d;
  logic [W-1:0]   cnt_q, cnt_d;

  // Free when empty, or when the held event is being taken this very cycle.
  assign slot_free_o = !valid_q || evt.evt_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    valid_d = valid_q;
    id_d    = id_q;
    type_d  = type_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      valid_d = 1'b1;
      id_d    = id_i;
      type_d  = type_i;
      cnt_d   = cnt_i;
    end else if (evt.evt_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (!rst_n) begin
      valid_q <= 1'b0;
      id_q    <= '0;
      type_q  <= RAISE;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      id_q    <= id_d;
      type_q  <= type_d;
      cnt_q   <= cnt_d;
    end
  end

  assign evt.evt_valid = valid_q;
  assign evt.evt_id    = id_q;
  assign evt.evt_type  = type_q;
  assign evt.evt_cnt   = cnt_q;

endmodule : cnt_mon_out_reg

// File: rtl/array_cnt_monitor.sv
// Round-robin threshold monitor with hysteresis over a counter array.
// Optional ARRAY_CNT_MON_IRQ_EN adds a registered irq output (OR of all alarms).
module array_cnt_monitor
  import array_cnt_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int N   = N_DEF,
  parameter int IDW = $clog2(N)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [W-1:0]        cnt [N],
  input  logic [W-1:0]        thr_hi,
  input  logic [W-1:0]        thr_lo,
  output logic [N-1:0]        alarm,
  array_cnt_monitor_if.master evt
`ifdef ARRAY_CNT_MON_IRQ_EN
  ,
  output logic                irq
`endif
);

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [N-1:0]   alarm_q, alarm_d;
  logic           slot_free;
  logic           advance;
  logic           load;
  evt_type_e      load_type;
  logic [W-1:0]   cur_cnt;

  assign advance = en && slot_free;
  assign cur_cnt = cnt[ptr_q];

  always_comb begin
    ptr_d     = ptr_q;
    alarm_d   = alarm_q;
    load      = 1'b0;
    load_type = RAISE;
    if (advance) begin
      ptr_d = (ptr_q == IDW'(N - 1)) ? '0 : ptr_q + IDW'(1);
      if (!alarm_q[ptr_q] && (cur_cnt >= thr_hi)) begin
        alarm_d[ptr_q] = 1'b1;
        load           = 1'b1;
        load_type      = RAISE;
      end else if (alarm_q[ptr_q] && (cur_cnt <= thr_lo) && (cur_cnt < thr_hi)) begin
        // The < thr_hi guard stops raise/clear ping-pong when thr_lo >= thr_hi.
        alarm_d[ptr_q] = 1'b0;
        load           = 1'b1;
        load_type      = CLEAR;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      alarm_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      alarm_q <= alarm_d;
    end
  end

  assign alarm = alarm_q;

  cnt_mon_out_reg #(
    .W   (W),
    .IDW (IDW)
  ) u_out_reg (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (load),
    .id_i        (ptr_q),
    .type_i      (load_type),
    .cnt_i       (cur_cnt),
    .slot_free_o (slot_free),
    .evt         (evt)
  );

`ifdef ARRAY_CNT_MON_IRQ_EN
  logic irq_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= |alarm_q;
    end
  end

  assign irq = irq_q;
`endif

endmodule : array_cnt_monitor

// File: doc/array_cnt_monitor.md
ARRAY_CNT_MONITOR -- requirements
Module: array_cnt_monitor

Interface
REQ-001 Parameter W, default 6: width of each monitored counter.
REQ-002 Parameter N, default 8: number of monitored counters.
REQ-003 Parameter IDW, default $clog2(N): counter index width.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 en  input  1  scan enable.
REQ-007 cnt  input  W x N unpacked array  counter values from the counter-array stage.
REQ-008 thr_hi  input  W  raise threshold.
REQ-009 thr_lo  input  W  clear threshold.
REQ-010 evt_valid  output  1  event available.
REQ-011 evt_ready  input  1  consumer accepts event.
REQ-012 evt_id  output  IDW  counter index of event.
REQ-013 evt_type  output  1  0 = RAISE, 1 = CLEAR.
REQ-014 evt_cnt  output  W  counter value sampled for event.
REQ-015 alarm  output  N  per-counter alarm flag.

Function
REQ-016 Scan pointer visits one index per advancing cycle, 0..N-1, then wraps to 0; it resets to 0 when N is not a power of two and the pointer reaches N-1.
REQ-017 Pointer advances only when en=1 and the output slot is free (evt_valid=0, or evt_valid=1 with evt_ready=1 in the same cycle).
REQ-018 Raise: alarm[i]=0 and cnt[i] >= thr_hi (unsigned) -> set alarm[i], load RAISE event.
REQ-019 Clear: alarm[i]=1, cnt[i] <= thr_lo and cnt[i] < thr_hi -> clear alarm[i], load CLEAR event.
REQ-020 Otherwise no event, alarm[i] unchanged, pointer still advances.
REQ-021 Latency: cnt sampled at edge t sets evt_valid and alarm at edge t+1; evt_cnt carries the value at t.
REQ-022 Handshake: evt_id, evt_type, evt_cnt stable while evt_valid=1 and evt_ready=0; evt_valid drops after acceptance unless a new event loads the same cycle (back-to-back, one event per cycle max).
REQ-023 Stall: pointer holds, no counter evaluated, alarm unchanged while the slot is occupied and not accepted.
REQ-024 en=0: pointer and alarm hold; a pending event remains valid until accepted.
REQ-025 thr_lo >= thr_hi: REQ-019 guard prevents raise/clear oscillation; thresholds are sampled every cycle, no latching.

Reset
REQ-026 rst_n low: pointer=0, alarm='0, evt_valid=0, evt_id=0, evt_type=0, evt_cnt=0, asynchronously.
REQ-027 Reset mid-handshake discards a pending event; first evaluation occurs on the first advancing cycle after rst_n deassertion.

Configuration
REQ-028 Macro ARRAY_CNT_MON_IRQ_EN defined: adds output irq (1 bit), registered, irq = OR of alarm, reset 0, one cycle behind alarm.
REQ-029 Macro undefined: no irq port, no related logic; all other behaviour identical.

Structure
REQ-030 Package array_cnt_pkg holds evt_type enum (RAISE=0, CLEAR=1) and defaults W_DEF=6, N_DEF=8, shared with the counter-array stage.
REQ-031 One sub-module cnt_mon_out_reg: valid/ready output register holding id/type/cnt, reporting slot-free to the scanner.

Verification
REQ-032 N=8, thr_hi=10, thr_lo=4, cnt[3]=10, evt_ready=1 -> one RAISE id=3 cnt=10, alarm[3]=1; no repeat on later scans.
REQ-033 After REQ-032, cnt[3]=4 -> one CLEAR id=3 cnt=4, alarm[3]=0; cnt[3]=5 -> no event.
REQ-034 cnt[0]=cnt[1]=63, evt_ready=0 for 5 cycles -> event id=0 held stable, pointer stuck at 1; release -> id=0 then id=1 on consecutive cycles.
REQ-035 thr_lo=12, thr_hi=10, cnt[2]=11 -> single RAISE, no CLEAR, for 3 full scans.
REQ-036 rst_n pulsed low while evt_valid=1 -> all outputs 0 immediately; alarms re-raise on next scan.
REQ-037 With ARRAY_CNT_MON_IRQ_EN: alarm[5] set -> irq=1 next cycle; cleared -> irq=0 next cycle.
